fpu_addsub_arbiter: RTL and testbench

Controller that shares one FP16 add/sub unit between two requesters.
- Arbitrates round-robin and captures the winner's operands.
- Launches the unit by pulsing its reset, then waits for its done.
- Returns result and OFUF tagged with the requester ID.
- A timeout counter guards against the unit never asserting done. Sits between the instruction-issue logic and the add/sub datapath.

---
 rtl/fpu_addsub_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_fpu_addsub_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_addsub_arbiter
//
// Shares one FP16 add/sub unit between two requesters. A round-robin grant
// picks a requester in IDLE, its operands are latched, the unit is launched
// by a one-cycle pulse on its reset, and the arbiter waits for the unit's
// done. The result and overflow/underflow flags come back tagged with the
// requester ID. A timeout counter forces a response (result 0, timeout flag
// set) if the unit never signals done.
//
// Optional build macro: ZERO_BYPASS_EN
//   When defined, an accepted operation with a zero operand skips the unit
//   and responds one cycle after the handshake.
//
// Handshake: a request transfers on any cycle where reqN_valid & reqN_ready
// are both high. reqN_ready depends only on arbiter state and the other
// requester's valid, never on the requester's own operands. There is no
// back-pressure on the response: resp_valid is a single-cycle pulse.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req0_* / req1_*                requester valid/ready, operands, add/sub
//   resp_valid/id/result/ofuf/timeout   tagged response
//   u_X, u_Y, u_addSub, u_reset    drive the shared add/sub unit
//   u_done, u_result, u_OFUF       status returned by the unit
//
// Parameters:
//   TIMEOUT_CYCLES  cycles spent in WAIT before a timeout response (>= 2)
//   CNT_W           timeout counter width, must hold TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module fpu_addsub_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_x,
    input  logic [15:0] req0_y,
    input  logic        req0_sub,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_x,
    input  logic [15:0] req1_y,
    input  logic        req1_sub,

    output logic        resp_valid,
    output logic        resp_id,
    output logic [15:0] resp_result,
    output logic [1:0]  resp_ofuf,
    output logic        resp_timeout,

    output logic [15:0] u_X,
    output logic [15:0] u_Y,
    output logic        u_addSub,
    output logic        u_reset,
    input  logic        u_done,
    input  logic [15:0] u_result,
    input  logic [1:0]  u_OFUF
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_RELEASE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_rr_ptr;
    logic [15:0]        r_x;
    logic [15:0]        r_y;
    logic               r_sub;
    logic               r_cur_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_res;
    logic [1:0]         r_ofuf;
    logic               r_timeout;

    logic               w_idle;
    logic               w_grant;
    logic               w_hs;
    logic [15:0]        w_sel_x;
    logic [15:0]        w_sel_y;
    logic               w_sel_sub;
    logic               w_bypass;
    logic               w_cnt_last;
`ifdef ZERO_BYPASS_EN
    logic [15:0]        w_bypass_res;
`endif

    // Grant: a lone valid requester wins; on contention rr_ptr decides.
    // With no valid request the grant simply parks on rr_ptr.
    always_comb begin
        w_grant = r_rr_ptr;
        if (req0_valid && !req1_valid) begin
            w_grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_idle     = (r_state == ST_IDLE);
    assign req0_ready = w_idle & ~reset & ~w_grant;
    assign req1_ready = w_idle & ~reset &  w_grant;
    assign w_hs       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign w_sel_x    = w_grant ? req1_x   : req0_x;
    assign w_sel_y    = w_grant ? req1_y   : req0_y;
    assign w_sel_sub  = w_grant ? req1_sub : req0_sub;

    assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef ZERO_BYPASS_EN
    assign w_bypass = (w_sel_x == 16'h0000) || (w_sel_y == 16'h0000);

    // 0 op y is y (sign flipped for subtract); x op 0 is x.
    always_comb begin
        w_bypass_res = w_sel_x;
        if (w_sel_x == 16'h0000 && w_sel_y == 16'h0000) begin
            w_bypass_res = 16'h0000;
        end else if (w_sel_x == 16'h0000) begin
            w_bypass_res = {w_sel_y[15] ^ w_sel_sub, w_sel_y[14:0]};
        end
    end
`else
    assign w_bypass = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_next = w_bypass ? ST_RESP : ST_LAUNCH;
                end
            end
            ST_LAUNCH:  w_next = ST_RELEASE;
            ST_RELEASE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (u_done || w_cnt_last) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand, arbitration and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr  <= 1'b0;
            r_x       <= 16'h0000;
            r_y       <= 16'h0000;
            r_sub     <= 1'b0;
            r_cur_id  <= 1'b0;
            r_cnt     <= '0;
            r_res     <= 16'h0000;
            r_ofuf    <= 2'b00;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_x      <= w_sel_x;
                        r_y      <= w_sel_y;
                        r_sub    <= w_sel_sub;
                        r_cur_id <= w_grant;
                        r_rr_ptr <= ~w_grant;
`ifdef ZERO_BYPASS_EN
                        if (w_bypass) begin
                            r_res     <= w_bypass_res;
                            r_ofuf    <= 2'b00;
                            r_timeout <= 1'b0;
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    r_cnt <= '0;
                end
                ST_WAIT: begin
                    // done wins over a timeout landing in the same cycle
                    if (u_done) begin
                        r_res     <= u_result;
                        r_ofuf    <= u_OFUF;
                        r_timeout <= 1'b0;
                    end else if (w_cnt_last) begin
                        r_res     <= 16'h0000;
                        r_ofuf    <= 2'b00;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The unit is held in reset whenever the arbiter is, and pulsed for
    // exactly the LAUNCH cycle; it may load operands from RELEASE on.
    assign u_reset      = reset | (r_state == ST_LAUNCH);
    assign u_X          = r_x;
    assign u_Y          = r_y;
    assign u_addSub     = r_sub;

    assign resp_valid   = (r_state == ST_RESP) & ~reset;
    assign resp_id      = r_cur_id;
    assign resp_result  = r_res;
    assign resp_ofuf    = r_ofuf;
    assign resp_timeout = r_timeout;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_addsub_arbiter
//
// Bench for fpu_addsub_arbiter with TIMEOUT_CYCLES=8. A behavioural unit
// stub raises done a programmable number of cycles after u_reset falls
// (or never). Expected responses come from the rules: latency 3+D for a
// done delay D within the timeout window, TIMEOUT+3 with a zero result
// otherwise, and strict alternation under contention.
// ---------------------------------------------------------------------------
module tb_fpu_addsub_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_sub;
    logic [15:0] req0_x, req0_y;
    logic        req1_valid, req1_ready, req1_sub;
    logic [15:0] req1_x, req1_y;
    logic        resp_valid, resp_id, resp_timeout;
    logic [15:0] resp_result;
    logic [1:0]  resp_ofuf;
    logic [15:0] u_X, u_Y, u_result;
    logic        u_addSub, u_reset, u_done;
    logic [1:0]  u_OFUF;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          g_hs_wait;

    // unit stub
    int          stub_cnt   = 0;
    int          stub_delay = 1;
    logic [15:0] stub_result = 16'h0000;
    logic [1:0]  stub_ofuf   = 2'b00;

    fpu_addsub_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_sub(req1_sub),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .resp_ofuf(resp_ofuf), .resp_timeout(resp_timeout),
        .u_X(u_X), .u_Y(u_Y), .u_addSub(u_addSub), .u_reset(u_reset),
        .u_done(u_done), .u_result(u_result), .u_OFUF(u_OFUF)
    );

    // ---------------- clock / reset / stub ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (u_reset) stub_cnt <= 0;
        else         stub_cnt <= stub_cnt + 1;
    end

    assign u_done   = !u_reset && (stub_delay > 0) && (stub_cnt >= stub_delay);
    assign u_result = stub_result;
    assign u_OFUF   = stub_ofuf;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int id, input logic v, input logic [15:0] x,
                         input logic [15:0] y, input logic sub);
        if (id == 0) begin
            req0_valid = v; req0_x = x; req0_y = y; req0_sub = sub;
        end else begin
            req1_valid = v; req1_x = x; req1_y = y; req1_sub = sub;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One complete operation from a single requester, checked end to end.
    task automatic do_op(input int id, input logic [15:0] x, input logic [15:0] y,
                         input logic sub, input int dly, input logic [15:0] sres,
                         input logic [1:0] sofuf);
        int          hs_cyc, lat, pulses, op_bad, exp_lat, exp_pulses;
        bit          got, rdy, byp;
        logic [15:0] exp_res;
        logic [1:0]  exp_of;
        logic        exp_to;
        byp = 1'b0;
`ifdef ZERO_BYPASS_EN
        byp = (x == 16'h0000) || (y == 16'h0000);
`endif
        if (byp) begin
            exp_lat = 1; exp_pulses = 0; exp_to = 1'b0; exp_of = 2'b00;
            if (x == 16'h0000 && y == 16'h0000) exp_res = 16'h0000;
            else if (x == 16'h0000)             exp_res = sub ? (y ^ 16'h8000) : y;
            else                                exp_res = x;
        end else if (dly >= 1 && dly <= TO) begin
            exp_lat = 3 + dly; exp_pulses = 1; exp_res = sres; exp_of = sofuf; exp_to = 1'b0;
        end else begin
            exp_lat = TO + 3; exp_pulses = 1; exp_res = 16'h0000; exp_of = 2'b00; exp_to = 1'b1;
        end
        stub_delay = dly; stub_result = sres; stub_ofuf = sofuf;

        @(posedge clk); #1;
        drive(id, 1'b1, x, y, sub);
        got = 1'b0; hs_cyc = 0; g_hs_wait = -1;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            rdy = (id == 0) ? req0_ready : req1_ready;
            if (rdy) begin got = 1'b1; hs_cyc = cyc; g_hs_wait = i; end
        end
        n_checks++;
        if (!got) begin
            $display("FAIL handshake req%0d: ready=0 for 16 cycles, required 1", id);
            n_fail++;
            drive(id, 1'b0, 16'h0, 16'h0, 1'b0);
            return;
        end
        // drop the request and scramble its inputs; operands must stay latched
        @(posedge clk); #1;
        drive(id, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));

        pulses = 0; op_bad = 0; got = 1'b0; lat = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (u_reset) pulses++;
            if (u_X !== x || u_Y !== y || u_addSub !== sub) op_bad++;
            if (resp_valid) begin got = 1'b1; lat = cyc - hs_cyc; end
        end
        n_checks++;
        if (!got) begin
            $display("FAIL resp_seen req%0d: no resp_valid within 40 cycles", id);
            n_fail++;
            return;
        end
        n_checks++;
        if (lat != exp_lat) begin
            $display("FAIL latency: got %0d required %0d", lat, exp_lat); n_fail++;
        end
        n_checks++;
        if (resp_id !== id[0]) begin
            $display("FAIL resp_id: got %0d required %0d", resp_id, id); n_fail++;
        end
        n_checks++;
        if (resp_result !== exp_res) begin
            $display("FAIL resp_result: got %h required %h", resp_result, exp_res); n_fail++;
        end
        n_checks++;
        if (resp_ofuf !== exp_of) begin
            $display("FAIL resp_ofuf: got %b required %b", resp_ofuf, exp_of); n_fail++;
        end
        n_checks++;
        if (resp_timeout !== exp_to) begin
            $display("FAIL resp_timeout: got %b required %b", resp_timeout, exp_to); n_fail++;
        end
        n_checks++;
        if (pulses != exp_pulses) begin
            $display("FAIL u_reset_pulse: got %0d cycles high required %0d", pulses, exp_pulses); n_fail++;
        end
        n_checks++;
        if (op_bad != 0) begin
            $display("FAIL operands_stable: %0d cycles with u_X/u_Y/u_addSub not %h/%h/%b",
                     op_bad, x, y, sub);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0) begin
            $display("FAIL resp_pulse_width: resp_valid=%b one cycle after RESP, required 0", resp_valid);
            n_fail++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (u_reset !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp_valid !== 1'b0) begin
            $display("FAIL in_reset: u_reset=%b r0=%b r1=%b rv=%b required 1 0 0 0",
                     u_reset, req0_ready, req1_ready, resp_valid);
            n_fail++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (u_reset !== 1'b0 || resp_valid !== 1'b0 || resp_id !== 1'b0 ||
            resp_result !== 16'h0000 || resp_ofuf !== 2'b00 || resp_timeout !== 1'b0) begin
            $display("FAIL after_reset: u_reset=%b rv=%b id=%b res=%h of=%b to=%b required all 0",
                     u_reset, resp_valid, resp_id, resp_result, resp_ofuf, resp_timeout);
            n_fail++;
        end
        n_checks++;
        if (u_X !== 16'h0000 || u_Y !== 16'h0000 || u_addSub !== 1'b0) begin
            $display("FAIL reset_operands: u_X=%h u_Y=%h sub=%b required 0", u_X, u_Y, u_addSub);
            n_fail++;
        end
    endtask

    task automatic test_single();
        do_op(0, 16'h3C00, 16'h4000, 1'b0, 2, 16'h4200, 2'b00);
    endtask

    task automatic test_contention();
        logic        exp_id_q[$];
        logic        exp_id;
        int          rr, win, resp_cyc;
        bit          got;
        apply_reset();
        stub_delay = 1; stub_result = 16'($urandom); stub_ofuf = 2'($urandom);
        rr = 0; resp_cyc = 0;
        drive(0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        drive(1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        for (int n = 0; n < 4; n++) begin
            got = 1'b0; win = 0;
            for (int i = 0; i < 16 && !got; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin got = 1'b1; win = req1_ready ? 1 : 0; end
            end
            n_checks++;
            if (!got) begin
                $display("FAIL contention_grant: no ready for 16 cycles"); n_fail++;
                break;
            end
            if (win != rr) begin
                $display("FAIL contention_grant: winner %0d required %0d", win, rr); n_fail++;
            end
            if (n > 0) begin
                n_checks++;
                if (cyc != resp_cyc + 1) begin
                    $display("FAIL back_to_back: handshake %0d cycles after RESP, required 1",
                             cyc - resp_cyc);
                    n_fail++;
                end
            end
            exp_id_q.push_back(rr[0]);
            rr = 1 - rr;
            @(posedge clk); #1;
            drive(win, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (resp_valid) begin got = 1'b1; resp_cyc = cyc; end
            end
            exp_id = exp_id_q.pop_front();
            n_checks++;
            if (!got) begin
                $display("FAIL contention_resp: no resp_valid within 20 cycles"); n_fail++;
                break;
            end
            if (resp_id !== exp_id || resp_result !== stub_result) begin
                $display("FAIL contention_resp: id=%b res=%h required id=%b res=%h",
                         resp_id, resp_result, exp_id, stub_result);
                n_fail++;
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
    endtask

    task automatic test_timeout();
        do_op(0, 16'h4400, 16'h3800, 1'b1, -1, 16'hBEEF, 2'b11);
        do_op(1, 16'h4000, 16'h4000, 1'b0, 3, 16'h4400, 2'b00);
    endtask

    task automatic test_done_timeout_tie();
        do_op(1, 16'h5000, 16'h1000, 1'b0, TO, 16'h1234, 2'b10);
        do_op(0, 16'h5000, 16'h1000, 1'b1, TO + 1, 16'h4321, 2'b01);
    endtask

    task automatic test_zero_operand();
        do_op(1, 16'h0000, 16'h4000, 1'b1, 2, 16'h5A5A, 2'b01);
        do_op(0, 16'h3C00, 16'h0000, 1'b1, 2, 16'h6B6B, 2'b00);
    endtask

    task automatic test_random();
        logic [15:0] x, y;
        for (int n = 0; n < 12; n++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if ($urandom_range(0, 5) == 0) x = 16'h0000;
            if ($urandom_range(0, 5) == 0) y = 16'h0000;
            do_op($urandom_range(0, 1), x, y, 1'($urandom), $urandom_range(1, TO + 3),
                  16'($urandom), 2'($urandom));
        end
    endtask

    task automatic test_reset_mid_wait();
        int  seen;
        bit  got;
        stub_delay = -1;
        @(posedge clk); #1;
        drive(0, 1'b1, 16'h4800, 16'h4000, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if (req0_ready) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            $display("FAIL midwait_handshake: req0 never granted"); n_fail++;
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (u_reset !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp_valid !== 1'b0) begin
            $display("FAIL midwait_in_reset: u_reset=%b r0=%b r1=%b rv=%b required 1 0 0 0",
                     u_reset, req0_ready, req1_ready, resp_valid);
            n_fail++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            $display("FAIL aborted_op_resp: %0d resp_valid cycles, required 0", seen); n_fail++;
        end
        n_checks++;
        if (resp_result !== 16'h0000 || resp_timeout !== 1'b0 || resp_id !== 1'b0) begin
            $display("FAIL midwait_resp_cleared: res=%h to=%b id=%b required 0",
                     resp_result, resp_timeout, resp_id);
            n_fail++;
        end
        // rr pointer is back at 0: both valid -> requester 0 first
        stub_delay = 1; stub_result = 16'h2468; stub_ofuf = 2'b00;
        @(posedge clk); #1;
        drive(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        drive(1, 1'b1, 16'h3333, 16'h4444, 1'b0);
        @(negedge clk);
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            $display("FAIL rr_after_reset: r0=%b r1=%b required 1 0", req0_ready, req1_ready);
            n_fail++;
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        n_checks++;
        if (!got || resp_id !== 1'b0) begin
            $display("FAIL rr_after_reset_resp: seen=%0d id=%b required seen=1 id=0", got, resp_id);
            n_fail++;
        end
        // a lone req1 is granted in its first cycle
        do_op(1, 16'h4200, 16'h3C00, 1'b1, 2, 16'h4000, 2'b00);
        n_checks++;
        if (g_hs_wait != 0) begin
            $display("FAIL req1_immediate_grant: waited %0d cycles required 0", g_hs_wait);
            n_fail++;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_done_timeout_tie();
        test_zero_operand();
        test_random();
        test_reset_mid_wait();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
